// File: rtl/div_pkg.sv
// Shared definitions for the divider pre-normalization stage: FSM states,
// operand/shift widths and the reciprocal seed table.
package div_pkg;

  localparam int OP_W = 8;
  localparam int SH_W = 3;
  localparam int N_W  = 2 * OP_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    SEED = 2'd2,
    DONE = 2'd3
  } state_t;

  // Reciprocal estimates (Q1.7) for the midpoint of each eighth of [0.5,1),
  // selected by the three bits right below the leading one of the divisor.
  // Entry 0 is the rightmost element.
  localparam logic [7:0][OP_W-1:0] SEED_TABLE = {
    8'd132, 8'd141, 8'd152, 8'd164, 8'd178, 8'd195, 8'd216, 8'd241
  };

  // Two's complement magnitude; -128 maps to 128, which fits 8 unsigned bits.
  function automatic logic [OP_W-1:0] magnitude(input logic [OP_W-1:0] v);
    return v[OP_W-1] ? (-v) : v;
  endfunction

endpackage

// File: rtl/div_prenorm_seed_rom.sv
// Combinational reciprocal seed lookup indexed by normalized divisor bits.
module seed_rom
  import div_pkg::*;
(
  input  logic [2:0]      idx,
  output logic [OP_W-1:0] seed
);

  assign seed = SEED_TABLE[idx];

endmodule

// File: rtl/div_prenorm.sv
// Divider front end: takes a signed operand pair, strips the signs, shifts
// the divisor left until its MSB is set (one bit per cycle, dividend
// follows), then attaches a reciprocal seed for the Goldschmidt stage.
module div_prenorm
  import div_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OP_W-1:0] a_in,
  input  logic [OP_W-1:0] b_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N_W-1:0]  n_out,
  output logic [OP_W-1:0] d_out,
  output logic [OP_W-1:0] seed_out,
  output logic [SH_W-1:0] shift_out,
  output logic            sign_out,
  output logic            dz_out
);

  state_t          state;
  logic [OP_W-1:0] seed_val;

  // The working divisor register doubles as d_out; once its MSB is set the
  // bits below it address the seed table.
  seed_rom u_seed_rom (
    .idx  (d_out[OP_W-2:OP_W-4]),
    .seed (seed_val)
  );

  // Control FSM with the working registers driven directly as outputs.
  // A zero divisor still passes through NORM for one cycle, which exits
  // straight to DONE without shifting, so its result appears one cycle
  // after accept with every data output cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      n_out     <= '0;
      d_out     <= '0;
      seed_out  <= '0;
      shift_out <= '0;
      sign_out  <= 1'b0;
      dz_out    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            in_ready  <= 1'b0;
            state     <= NORM;
            seed_out  <= '0;
            shift_out <= '0;
            if (b_in == '0) begin
              n_out    <= '0;
              d_out    <= '0;
              sign_out <= 1'b0;
              dz_out   <= 1'b1;
            end else begin
              n_out    <= {{OP_W{1'b0}}, magnitude(a_in)};
              d_out    <= magnitude(b_in);
              sign_out <= a_in[OP_W-1] ^ b_in[OP_W-1];
              dz_out   <= 1'b0;
            end
          end
        end
        NORM: begin
          if (dz_out) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end else if (d_out[OP_W-1]) begin
            state <= SEED;
          end else begin
            d_out     <= d_out << 1;
            n_out     <= n_out << 1;
            shift_out <= shift_out + SH_W'(1);
          end
        end
        SEED: begin
          seed_out  <= seed_val;
          state     <= DONE;
          out_valid <= 1'b1;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_prenorm.sv
// Self-checking bench for div_prenorm: directed vector table, backpressure
// and mid-operation reset sequences, then randomized operand pairs checked
// against an arithmetic reference model.
module tb_div_prenorm;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a_in;
  logic [7:0]  b_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] n_out;
  logic [7:0]  d_out;
  logic [7:0]  seed_out;
  logic [2:0]  shift_out;
  logic        sign_out;
  logic        dz_out;

  int total;
  int bad;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] n;
    logic [7:0]  d;
    logic [7:0]  seed;
    logic [2:0]  s;
    logic        sg;
    logic        dz;
    int          lat;
  } vec_t;

  vec_t vecs[10];

  div_prenorm dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .n_out     (n_out),
    .d_out     (d_out),
    .seed_out  (seed_out),
    .shift_out (shift_out),
    .sign_out  (sign_out),
    .dz_out    (dz_out)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Reference: magnitudes, smallest shift bringing |B| into [128,256),
  // seed = 1/midpoint of the divisor's eighth of [0.5,1) rounded to Q1.7.
  task automatic model(input logic [7:0] a, input logic [7:0] b, output vec_t r);
    int ma, mb, sh, dv, idx, mid;
    ma = (a >= 8'd128) ? 256 - int'(a) : int'(a);
    mb = (b >= 8'd128) ? 256 - int'(b) : int'(b);
    r.a = a;
    r.b = b;
    if (mb == 0) begin
      r.n = '0; r.d = '0; r.seed = '0; r.s = '0; r.sg = 1'b0; r.dz = 1'b1; r.lat = 1;
    end else begin
      sh = 0;
      dv = mb;
      while (dv < 128) begin
        dv = dv * 2;
        sh++;
      end
      idx    = (dv - 128) / 16;
      mid    = 136 + 16 * idx;
      r.n    = 16'(ma * (1 << sh));
      r.d    = 8'(dv);
      r.seed = 8'((32768 + mid / 2) / mid);
      r.s    = 3'(sh);
      r.sg   = a[7] ^ b[7];
      r.dz   = 1'b0;
      r.lat  = sh + 2;
    end
  endtask

  task automatic check_fields(input string tag, input vec_t e);
    check_output({tag, " n_out"},     int'(n_out),     int'(e.n));
    check_output({tag, " d_out"},     int'(d_out),     int'(e.d));
    check_output({tag, " seed_out"},  int'(seed_out),  int'(e.seed));
    check_output({tag, " shift_out"}, int'(shift_out), int'(e.s));
    check_output({tag, " sign_out"},  int'(sign_out),  int'(e.sg));
    check_output({tag, " dz_out"},    int'(dz_out),    int'(e.dz));
  endtask

  // One full transaction: accept, measure latency, check result, optional
  // backpressure hold with junk operands, then handshake back to IDLE.
  task automatic apply_stimulus(input string tag, input vec_t e, input bit junk,
                                input bit early_ready, input int hold);
    int cnt;
    cnt = 0;
    while (!in_ready && cnt < 30) begin
      @(posedge clk); #1;
      cnt++;
    end
    check_output({tag, " in_ready before accept"}, int'(in_ready), 1);
    out_ready = early_ready;
    in_valid  = 1'b1;
    a_in      = e.a;
    b_in      = e.b;
    @(posedge clk); #1;
    in_valid = junk;
    if (junk) begin
      a_in = 8'($urandom);
      b_in = 8'($urandom);
    end
    cnt = 0;
    while (!out_valid && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    check_output({tag, " latency"}, cnt, e.lat);
    check_fields(tag, e);
    if (!early_ready) begin
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        check_output({tag, " held out_valid"}, int'(out_valid), 1);
        check_output({tag, " held in_ready"},  int'(in_ready),  0);
        check_output({tag, " held n_out"},     int'(n_out),     int'(e.n));
        check_output({tag, " held seed_out"},  int'(seed_out),  int'(e.seed));
      end
      if (hold > 0) check_fields({tag, " after hold"}, e);
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check_output({tag, " in_ready after handshake"},  int'(in_ready),  1);
    check_output({tag, " out_valid after handshake"}, int'(out_valid), 0);
  endtask

  initial begin
    vec_t e;
    int   seen;
    string tag;
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a_in      = '0;
    b_in      = '0;

    vecs[0] = '{8'd6,   8'd3,   16'h0180, 8'hC0, 8'd164, 3'd6, 1'b0, 1'b0, 8};
    vecs[1] = '{8'hF9,  8'd5,   16'h00E0, 8'hA0, 8'd195, 3'd5, 1'b1, 1'b0, 7};
    vecs[2] = '{8'h9C,  8'h80,  16'h0064, 8'h80, 8'd241, 3'd0, 1'b0, 1'b0, 2};
    vecs[3] = '{8'd5,   8'd0,   16'h0000, 8'h00, 8'd0,   3'd0, 1'b0, 1'b1, 1};
    vecs[4] = '{8'd0,   8'd7,   16'h0000, 8'hE0, 8'd141, 3'd5, 1'b0, 1'b0, 7};
    vecs[5] = '{8'h80,  8'd1,   16'h4000, 8'h80, 8'd241, 3'd7, 1'b1, 1'b0, 9};
    vecs[6] = '{8'h7F,  8'hFF,  16'h3F80, 8'h80, 8'd241, 3'd7, 1'b1, 1'b0, 9};
    vecs[7] = '{8'd0,   8'hFD,  16'h0000, 8'hC0, 8'd164, 3'd6, 1'b1, 1'b0, 8};
    vecs[8] = '{8'hFB,  8'd0,   16'h0000, 8'h00, 8'd0,   3'd0, 1'b0, 1'b1, 1};
    vecs[9] = '{8'd3,   8'h7F,  16'h0006, 8'hFE, 8'd132, 3'd1, 1'b0, 1'b0, 3};

    #12;
    check_output("reset in_ready",  int'(in_ready),  1);
    check_output("reset out_valid", int'(out_valid), 0);
    check_output("reset n_out",     int'(n_out),     0);
    check_output("reset dz_out",    int'(dz_out),    0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] directed vectors");
    for (int i = 0; i < 10; i++) begin
      tag = $sformatf("vec%0d", i);
      apply_stimulus(tag, vecs[i], 1'b0, 1'b0, 0);
    end

    $display("[TB] backpressure with ignored operands");
    apply_stimulus("backpressure", vecs[0], 1'b1, 1'b0, 5);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check_output("no result from ignored operands", seen, 0);

    $display("[TB] reset during normalization");
    in_valid = 1'b1;
    a_in     = 8'd1;
    b_in     = 8'd1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    check_output("mid reset in_ready",  int'(in_ready),  1);
    check_output("mid reset out_valid", int'(out_valid), 0);
    check_output("mid reset n_out",     int'(n_out),     0);
    check_output("mid reset d_out",     int'(d_out),     0);
    check_output("mid reset seed_out",  int'(seed_out),  0);
    check_output("mid reset shift_out", int'(shift_out), 0);
    check_output("mid reset sign_out",  int'(sign_out),  0);
    check_output("mid reset dz_out",    int'(dz_out),    0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check_output("no out_valid after reset release", seen, 0);
    check_output("in_ready after reset release", int'(in_ready), 1);
    apply_stimulus("post reset", vecs[1], 1'b0, 1'b0, 0);

    $display("[TB] randomized operands");
    for (int i = 0; i < 150; i++) begin
      logic [7:0] ra, rb;
      bit         junk, early;
      int         hold;
      ra = 8'($urandom);
      rb = 8'($urandom);
      if ($urandom_range(0, 9) == 0) rb = 8'd0;
      else if ($urandom_range(0, 3) == 0) rb = 8'($urandom_range(0, 3)) - 8'd2;
      if ($urandom_range(0, 9) == 0) ra = 8'd0;
      junk  = 1'($urandom_range(0, 1));
      early = 1'($urandom_range(0, 1));
      hold  = $urandom_range(0, 3);
      model(ra, rb, e);
      tag = $sformatf("rand%0d a=%0d b=%0d", i, ra, rb);
      apply_stimulus(tag, e, junk, early, hold);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
